// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory arbiter and its load-extension helper:
// funct3 codes, FSM encoding, request payload and the request legality check.
package dmem_pkg;

    localparam int unsigned DEF_MEM_WORDS = 1024;
    localparam int unsigned XLEN          = 32;
    localparam int unsigned F3_W_BITS     = 3;

    localparam logic [F3_W_BITS-1:0] F3_B  = 3'd0;
    localparam logic [F3_W_BITS-1:0] F3_H  = 3'd1;
    localparam logic [F3_W_BITS-1:0] F3_W  = 3'd2;
    localparam logic [F3_W_BITS-1:0] F3_BU = 3'd4;
    localparam logic [F3_W_BITS-1:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    typedef struct packed {
        logic                 write;
        logic [XLEN-1:0]      addr;
        logic [XLEN-1:0]      wdata;
        logic [F3_W_BITS-1:0] funct3;
    } dmem_req_t;

    // Out-of-range, misaligned, or a size code the access direction cannot use.
    function automatic logic req_error(input dmem_req_t req, input logic [XLEN:0] byte_limit);
        logic err;
        err = ({1'b0, req.addr} >= byte_limit);
        case (req.funct3)
            F3_B, F3_BU: err = err;
            F3_H, F3_HU: err = err | req.addr[0];
            F3_W:        err = err | (req.addr[1:0] != 2'b00);
            default:     err = 1'b1;
        endcase
        if (req.write && (req.funct3 > F3_W)) begin
            err = 1'b1;
        end
        return err;
    endfunction

endpackage

// File: rtl/data_memory_arbiter_if.sv
// One requester's request/response channel into the data memory arbiter.
interface data_memory_arbiter_if;
    import dmem_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [XLEN-1:0]      req_addr;
    logic [XLEN-1:0]      req_wdata;
    logic [F3_W_BITS-1:0] req_funct3;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [XLEN-1:0]      rsp_rdata;
    logic                 rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_funct3, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_funct3, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/load_extend.sv
// Selects the byte/half/word of a memory word by byte offset and applies the
// RV32I sign or zero extension given by funct3.
module load_extend
    import dmem_pkg::*;
(
    input  logic [XLEN-1:0]      word,
    input  logic [1:0]           byte_off,
    input  logic [F3_W_BITS-1:0] funct3,
    output logic [XLEN-1:0]      result
);

    logic [7:0]  byte_c;
    logic [15:0] half_c;

    always_comb begin
        byte_c = word[{byte_off, 3'b000} +: 8];
        half_c = byte_off[1] ? word[31:16] : word[15:0];
        result = '0;
        case (funct3)
            F3_B:    result = {{24{byte_c[7]}}, byte_c};
            F3_H:    result = {{16{half_c[15]}}, half_c};
            F3_W:    result = word;
            F3_BU:   result = {24'd0, byte_c};
            F3_HU:   result = {16'd0, half_c};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter and single-outstanding access sequencer in front of the
// single-ported data memory; returns extended load data to the granted port.
module data_memory_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned MEM_WORDS = DEF_MEM_WORDS
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    data_memory_arbiter_if.slave p0,
    data_memory_arbiter_if.slave p1,
    output logic [XLEN-1:0]      mem_address,
    output logic                 mem_write,
    output logic                 mem_read,
    output logic [XLEN-1:0]      mem_wdata,
    output logic [F3_W_BITS-1:0] mem_store_sel,
    input  logic [XLEN-1:0]      mem_rdata
);

    localparam logic [XLEN:0] BYTE_LIMIT = 33'(MEM_WORDS) << 2;

    state_e                  state_q;
    logic                    last_grant_q;
    logic                    owner_q;
    logic                    mem_write_q;
    logic [1:0]              rsp_valid_q;
    logic [1:0]              rsp_err_q;
    logic [1:0][XLEN-1:0]    rsp_rdata_q;

    logic                    win0_c;
    logic                    win1_c;
    logic                    sel_err_c;
    logic                    rsp_fire_c;
    dmem_req_t               sel_req_c;
    logic [XLEN-1:0]         load_word_c;

    // On a tie the port that was not granted last wins.
    always_comb begin
        win0_c     = p0.req_valid & (~p1.req_valid | last_grant_q);
        win1_c     = p1.req_valid & ~win0_c;
        sel_req_c  = win1_c ? {p1.req_write, p1.req_addr, p1.req_wdata, p1.req_funct3}
                            : {p0.req_write, p0.req_addr, p0.req_wdata, p0.req_funct3};
        sel_err_c  = req_error(sel_req_c, BYTE_LIMIT);
        rsp_fire_c = owner_q ? p1.rsp_ready : p0.rsp_ready;
    end

    assign p0.req_ready = (state_q == ST_IDLE) & win0_c;
    assign p1.req_ready = (state_q == ST_IDLE) & win1_c;
    assign p0.rsp_valid = rsp_valid_q[0];
    assign p1.rsp_valid = rsp_valid_q[1];
    assign p0.rsp_err   = rsp_err_q[0];
    assign p1.rsp_err   = rsp_err_q[1];
    assign p0.rsp_rdata = rsp_rdata_q[0];
    assign p1.rsp_rdata = rsp_rdata_q[1];

    // Reset asserted mid-ACCESS must not let the pending store reach memory.
    assign mem_write = mem_write_q & rst_n_in;

    load_extend u_load_extend (
        .word     (mem_rdata),
        .byte_off (mem_address[1:0]),
        .funct3   (mem_store_sel),
        .result   (load_word_c)
    );

    // The mem_* registers double as the transaction holding registers.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= 1'b1;
            owner_q       <= 1'b0;
            mem_address   <= '0;
            mem_write_q   <= 1'b0;
            mem_read      <= 1'b0;
            mem_wdata     <= '0;
            mem_store_sel <= '0;
            rsp_valid_q   <= '0;
            rsp_err_q     <= '0;
            rsp_rdata_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (win0_c || win1_c) begin
                        owner_q      <= win1_c;
                        last_grant_q <= win1_c;
                        if (sel_err_c) begin
                            rsp_valid_q[win1_c] <= 1'b1;
                            rsp_err_q[win1_c]   <= 1'b1;
                            rsp_rdata_q[win1_c] <= '0;
                            state_q             <= ST_RESP;
                        end else begin
                            mem_address   <= sel_req_c.addr;
                            mem_write_q   <= sel_req_c.write;
                            mem_read      <= ~sel_req_c.write;
                            mem_wdata     <= sel_req_c.wdata;
                            mem_store_sel <= sel_req_c.funct3;
                            state_q       <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    rsp_valid_q[owner_q] <= 1'b1;
                    rsp_err_q[owner_q]   <= 1'b0;
                    rsp_rdata_q[owner_q] <= mem_write_q ? '0 : load_word_c;
                    mem_address          <= '0;
                    mem_write_q          <= 1'b0;
                    mem_read             <= 1'b0;
                    mem_wdata            <= '0;
                    mem_store_sel        <= '0;
                    state_q              <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_fire_c) begin
                        rsp_valid_q <= '0;
                        rsp_err_q   <= '0;
                        rsp_rdata_q <= '0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Self-checking bench for data_memory_arbiter: table of single transactions,
// plus contention, response back-pressure and reset-during-access sequences.
module tb_data_memory_arbiter;
    import dmem_pkg::*;

    typedef struct {
        bit          port;
        bit          write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    typedef struct {
        bit          port;
        logic [31:0] rdata;
        bit          err;
        int          id;
    } exp_t;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [31:0] mem_address;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_store_sel;
    logic [31:0] mem_rdata;
    logic [31:0] mem_arr [0:1023];

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    logic [1:0]  req_ready_w;
    logic [1:0]  rsp_valid_w;
    logic [1:0]  rsp_ready_w;
    logic [1:0]  rsp_err_w;
    logic [31:0] rsp_rdata_w [2];

    always #5 clk_in = ~clk_in;

    data_memory_arbiter_if p0_if ();
    data_memory_arbiter_if p1_if ();

    data_memory_arbiter #(.MEM_WORDS(1024)) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .p0            (p0_if),
        .p1            (p1_if),
        .mem_address   (mem_address),
        .mem_write     (mem_write),
        .mem_read      (mem_read),
        .mem_wdata     (mem_wdata),
        .mem_store_sel (mem_store_sel),
        .mem_rdata     (mem_rdata)
    );

    assign req_ready_w    = {p1_if.req_ready, p0_if.req_ready};
    assign rsp_valid_w    = {p1_if.rsp_valid, p0_if.rsp_valid};
    assign rsp_ready_w    = {p1_if.rsp_ready, p0_if.rsp_ready};
    assign rsp_err_w      = {p1_if.rsp_err, p0_if.rsp_err};
    assign rsp_rdata_w[0] = p0_if.rsp_rdata;
    assign rsp_rdata_w[1] = p1_if.rsp_rdata;

    // Memory with combinational read and byte/half/word write on the clock edge.
    assign mem_rdata = mem_arr[mem_address[11:2]];
    initial begin
        for (int i = 0; i < 1024; i++) mem_arr[i] <= '0;
    end
    always @(posedge clk_in) begin
        if (mem_write) begin
            case (mem_store_sel)
                3'd0:    mem_arr[mem_address[11:2]][{mem_address[1:0], 3'b000} +: 8] <= mem_wdata[7:0];
                3'd1:    mem_arr[mem_address[11:2]][{mem_address[1], 4'b0000} +: 16] <= mem_wdata[15:0];
                default: mem_arr[mem_address[11:2]] <= mem_wdata;
            endcase
        end
    end

    task automatic check(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s [%0d]: got 0x%08h, want 0x%08h", nm, id, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit port, input bit wr, input logic [31:0] a, input logic [31:0] d,
                                input logic [2:0] f, input logic [31:0] er, input bit ee);
        vec_t v;
        v.port = port; v.write = wr; v.addr = a; v.wdata = d; v.f3 = f;
        v.exp_rdata = er; v.exp_err = ee;
        return v;
    endfunction

    function automatic exp_t mk_exp(input bit port, input logic [31:0] rd, input bit err, input int id);
        exp_t e;
        e.port = port; e.rdata = rd; e.err = err; e.id = id;
        return e;
    endfunction

    // Scoreboard: every consumed response is matched against the oldest expectation.
    always @(negedge clk_in) begin
        for (int p = 0; p < 2; p++) begin
            if (rsp_valid_w[p] && rsp_ready_w[p]) begin
                if (sb_q.size() == 0) begin
                    check("rsp_unexpected", p, 32'(1), 32'(0));
                end else begin
                    mon_e = sb_q.pop_front();
                    check("rsp_port", mon_e.id, 32'(p), 32'(mon_e.port));
                    check("rsp_rdata", mon_e.id, rsp_rdata_w[p], mon_e.rdata);
                    check("rsp_err", mon_e.id, 32'(rsp_err_w[p]), 32'(mon_e.err));
                end
            end
        end
    end

    task automatic drive_req(input bit port, input bit v, input bit wr, input logic [31:0] a,
                             input logic [31:0] d, input logic [2:0] f);
        if (port) begin
            p1_if.req_valid = v; p1_if.req_write = wr; p1_if.req_addr = a;
            p1_if.req_wdata = d; p1_if.req_funct3 = f;
        end else begin
            p0_if.req_valid = v; p0_if.req_write = wr; p0_if.req_addr = a;
            p0_if.req_wdata = d; p0_if.req_funct3 = f;
        end
    endtask

    task automatic wait_accept(input bit port, output bit acc);
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge clk_in);
            acc = req_ready_w[port];
            @(posedge clk_in); #1;
        end
    endtask

    task automatic wait_rsp(input bit port, output int lat, output bit saw_mem);
        lat = 0;
        saw_mem = 1'b0;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            @(negedge clk_in);
            if (mem_write || mem_read) saw_mem = 1'b1;
            if (rsp_valid_w[port]) lat = k;
        end
        @(posedge clk_in); #1;
    endtask

    task automatic check_idle_outputs(input int id);
        check("idle_req_ready", id, 32'(req_ready_w), 32'(0));
        check("idle_rsp_valid", id, 32'(rsp_valid_w), 32'(0));
        check("idle_rsp_err", id, 32'(rsp_err_w), 32'(0));
        check("idle_rsp_rdata0", id, rsp_rdata_w[0], 32'(0));
        check("idle_rsp_rdata1", id, rsp_rdata_w[1], 32'(0));
        check("idle_mem_address", id, mem_address, 32'(0));
        check("idle_mem_wdata", id, mem_wdata, 32'(0));
        check("idle_mem_ctrl", id, 32'({mem_write, mem_read, mem_store_sel}), 32'(0));
    endtask

    task automatic do_txn(input int id, input vec_t v);
        bit acc;
        int lat;
        bit saw_mem;
        sb_q.push_back(mk_exp(v.port, v.exp_rdata, v.exp_err, id));
        drive_req(v.port, 1'b1, v.write, v.addr, v.wdata, v.f3);
        wait_accept(v.port, acc);
        drive_req(v.port, 1'b0, 1'b0, 32'(0), 32'(0), 3'd0);
        check("accept", id, 32'(acc), 32'(1));
        if (!acc) begin
            void'(sb_q.pop_back());
            return;
        end
        wait_rsp(v.port, lat, saw_mem);
        check("latency", id, 32'(lat), v.exp_err ? 32'(1) : 32'(2));
        if (v.exp_err) check("err_mem_quiet", id, 32'(saw_mem), 32'(0));
        check("sb_drain", id, 32'(sb_q.size()), 32'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        bit   acc;
        int   lat;
        bit   saw_mem;
        int   granted;
        bit   g1;

        vecs.push_back(mk(0, 1, 32'h10,   32'hDEADBEEF, F3_W,  32'h0,        0));
        vecs.push_back(mk(1, 0, 32'h10,   32'h0,        F3_W,  32'hDEADBEEF, 0));
        vecs.push_back(mk(0, 1, 32'h10,   32'h0,        F3_W,  32'h0,        0));
        vecs.push_back(mk(1, 1, 32'h13,   32'h12345680, F3_B,  32'h0,        0));
        vecs.push_back(mk(0, 0, 32'h13,   32'h0,        F3_B,  32'hFFFFFF80, 0));
        vecs.push_back(mk(1, 0, 32'h13,   32'h0,        F3_BU, 32'h00000080, 0));
        vecs.push_back(mk(0, 0, 32'h12,   32'h0,        F3_HU, 32'h00008000, 0));
        vecs.push_back(mk(1, 0, 32'h12,   32'h0,        F3_H,  32'hFFFF8000, 0));
        vecs.push_back(mk(0, 0, 32'h12,   32'h0,        F3_B,  32'h0,        0));
        vecs.push_back(mk(1, 1, 32'h14,   32'hDEADBEEF, F3_W,  32'h0,        0));
        vecs.push_back(mk(0, 0, 32'h15,   32'h0,        F3_B,  32'hFFFFFFBE, 0));
        vecs.push_back(mk(1, 0, 32'h14,   32'h0,        F3_BU, 32'h000000EF, 0));
        vecs.push_back(mk(0, 0, 32'h16,   32'h0,        F3_H,  32'hFFFFDEAD, 0));
        vecs.push_back(mk(1, 0, 32'h14,   32'h0,        F3_HU, 32'h0000BEEF, 0));
        vecs.push_back(mk(0, 1, 32'h22,   32'hABCD1234, F3_H,  32'h0,        0));
        vecs.push_back(mk(1, 0, 32'h20,   32'h0,        F3_W,  32'h12340000, 0));
        vecs.push_back(mk(0, 1, 32'hFFC,  32'h0BADF00D, F3_W,  32'h0,        0));
        vecs.push_back(mk(1, 0, 32'hFFF,  32'h0,        F3_BU, 32'h0000000B, 0));
        vecs.push_back(mk(0, 0, 32'h21,   32'h0,        F3_H,  32'h0,        1));
        vecs.push_back(mk(1, 0, 32'h22,   32'h0,        F3_W,  32'h0,        1));
        vecs.push_back(mk(0, 1, 32'h1000, 32'h11111111, F3_W,  32'h0,        1));
        vecs.push_back(mk(1, 0, 32'h0,    32'h0,        3'd3,  32'h0,        1));
        vecs.push_back(mk(0, 1, 32'h0,    32'h55555555, 3'd4,  32'h0,        1));
        vecs.push_back(mk(1, 0, 32'h0,    32'h0,        3'd7,  32'h0,        1));
        vecs.push_back(mk(0, 1, 32'h11,   32'h0000FFFF, F3_H,  32'h0,        1));
        vecs.push_back(mk(1, 0, 32'h10,   32'h0,        F3_W,  32'h80000000, 0));
        vecs.push_back(mk(0, 0, 32'h1000, 32'h0,        F3_W,  32'h0,        1));
        vecs.push_back(mk(1, 1, 32'h40,   32'hCAFEF00D, F3_W,  32'h0,        0));

        rst_n_in = 1'b0;
        drive_req(0, 1'b0, 1'b0, 32'(0), 32'(0), 3'd0);
        drive_req(1, 1'b0, 1'b0, 32'(0), 32'(0), 3'd0);
        p0_if.rsp_ready = 1'b1;
        p1_if.rsp_ready = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
        @(negedge clk_in);
        check_idle_outputs(-1);
        @(posedge clk_in); #1;
        rst_n_in = 1'b1;
        @(negedge clk_in);
        check_idle_outputs(-2);
        @(posedge clk_in); #1;

        foreach (vecs[i]) do_txn(i, vecs[i]);

        // p1 response held back; p0 must wait for it.
        p1_if.rsp_ready = 1'b0;
        sb_q.push_back(mk_exp(1, 32'h0BADF00D, 0, 100));
        drive_req(1, 1'b1, 1'b0, 32'hFFC, 32'(0), F3_W);
        wait_accept(1, acc);
        check("bp_p1_accept", 100, 32'(acc), 32'(1));
        drive_req(1, 1'b0, 1'b0, 32'(0), 32'(0), 3'd0);
        sb_q.push_back(mk_exp(0, 32'hDEADBEEF, 0, 101));
        drive_req(0, 1'b1, 1'b0, 32'h14, 32'(0), F3_W);
        wait_rsp(1, lat, saw_mem);
        check("bp_p1_latency", 100, 32'(lat), 32'(2));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_in);
            check("bp_hold_valid", 110 + k, 32'(rsp_valid_w[1]), 32'(1));
            check("bp_hold_data", 110 + k, rsp_rdata_w[1], 32'h0BADF00D);
            check("bp_p0_blocked", 110 + k, 32'(req_ready_w[0]), 32'(0));
            @(posedge clk_in); #1;
        end
        p1_if.rsp_ready = 1'b1;
        wait_accept(0, acc);
        check("bp_p0_accept", 101, 32'(acc), 32'(1));
        drive_req(0, 1'b0, 1'b0, 32'(0), 32'(0), 3'd0);
        wait_rsp(0, lat, saw_mem);
        check("bp_p0_latency", 101, 32'(lat), 32'(2));
        check("bp_drain", 101, 32'(sb_q.size()), 32'(0));

        // Reset while a store to 0x40 is in ACCESS.
        drive_req(0, 1'b1, 1'b1, 32'h40, 32'h12345678, F3_W);
        wait_accept(0, acc);
        check("rst_accept", 200, 32'(acc), 32'(1));
        rst_n_in = 1'b0;
        drive_req(0, 1'b0, 1'b0, 32'(0), 32'(0), 3'd0);
        @(posedge clk_in); #1;
        @(negedge clk_in);
        check_idle_outputs(200);
        check("rst_mem_kept", 201, mem_arr[16], 32'hCAFEF00D);
        @(posedge clk_in); #1;
        rst_n_in = 1'b1;

        // Both ports stream loads: grants alternate, p0 first after reset.
        for (int i = 0; i < 6; i++) begin
            sb_q.push_back(mk_exp(i[0], i[0] ? 32'h80000000 : 32'hDEADBEEF, 0, 300 + i));
        end
        drive_req(0, 1'b1, 1'b0, 32'h14, 32'(0), F3_W);
        drive_req(1, 1'b1, 1'b0, 32'h10, 32'(0), F3_W);
        granted = 0;
        for (int k = 0; k < 100 && granted < 6; k++) begin
            @(negedge clk_in);
            g1 = req_ready_w[1];
            if (req_ready_w != 2'b00) begin
                check("grant_order", 300 + granted, 32'(g1), 32'(granted % 2));
                granted++;
            end
            @(posedge clk_in); #1;
        end
        drive_req(0, 1'b0, 1'b0, 32'(0), 32'(0), 3'd0);
        drive_req(1, 1'b0, 1'b0, 32'(0), 32'(0), 3'd0);
        check("grant_count", 306, 32'(granted), 32'(6));
        for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(negedge clk_in);
        @(posedge clk_in); #1;
        check("rr_drain", 306, 32'(sb_q.size()), 32'(0));

        do_txn(400, mk(0, 0, 32'h40, 32'h0, F3_W, 32'hCAFEF00D, 0));

        @(negedge clk_in);
        check_idle_outputs(500);
        check("final_drain", 500, 32'(sb_q.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
